// File: rtl/dac_sample_feeder.sv
// Assembles low-byte-first 16-bit samples into a FIFO and paces them out to the DAC driver.
// Optional macro DAC_FEEDER_HOLD_LAST_EN re-issues the last sample on an empty-FIFO tick.
module dac_sample_feeder #(
    parameter int unsigned FIFO_DEPTH      = 16,
    parameter int unsigned CLKS_PER_SAMPLE = 250
) (
    input  logic                        clock_in,
    input  logic                        reset,
    input  logic [7:0]                  byte_data,
    input  logic                        byte_valid,
    input  logic                        flags_clr,
    output logic [15:0]                 dac_data,
    output logic                        dac_rq,
    input  logic                        dac_st,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow,
    output logic                        underrun
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned PW = $clog2(CLKS_PER_SAMPLE);
    localparam logic [PW-1:0] PacerMax  = PW'(CLKS_PER_SAMPLE - 1);
    localparam logic [LW-1:0] LevelFull = LW'(FIFO_DEPTH);

    typedef enum logic {ByteLow, ByteHigh} byte_st_e;
    typedef enum logic [1:0] {IssIdle, IssReq, IssWaitDone} issue_st_e;

    byte_st_e      byte_st_q, byte_st_d;
    issue_st_e     issue_st_q, issue_st_d;
    logic [7:0]    low_byte_q, low_byte_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [PW-1:0] pacer_q, pacer_d;
    logic [15:0]   dac_data_q, dac_data_d;
    logic          dac_rq_q, dac_rq_d;
    logic          overflow_q, overflow_d;
    logic          underrun_q, underrun_d;
    logic [15:0]   mem_q [FIFO_DEPTH];

    logic        push, push_ok, pop, tick, fifo_empty, fifo_full, underrun_evt;
    logic [15:0] push_word;

    always_comb begin
        push       = byte_valid && (byte_st_q == ByteHigh);
        push_word  = {byte_data, low_byte_q};
        fifo_empty = (level_q == '0);
        fifo_full  = (level_q == LevelFull);
        push_ok    = push && !fifo_full;
        tick       = (pacer_q == PacerMax);
        pacer_d    = tick ? '0 : pacer_q + PW'(1);
    end

    always_comb begin
        byte_st_d  = byte_st_q;
        low_byte_d = low_byte_q;
        if (byte_valid) begin
            if (byte_st_q == ByteLow) begin
                low_byte_d = byte_data;
                byte_st_d  = ByteHigh;
            end else begin
                byte_st_d = ByteLow;
            end
        end
    end

    always_comb begin
        issue_st_d   = issue_st_q;
        dac_rq_d     = dac_rq_q;
        dac_data_d   = dac_data_q;
        pop          = 1'b0;
        underrun_evt = 1'b0;
        unique case (issue_st_q)
            IssIdle: begin
                if (tick) begin
                    if (dac_st) begin
                        // Driver still busy: never raise a request on top of it.
                        underrun_evt = 1'b1;
                    end else if (!fifo_empty) begin
                        pop        = 1'b1;
                        dac_data_d = mem_q[rd_ptr_q];
                        dac_rq_d   = 1'b1;
                        issue_st_d = IssReq;
                    end else begin
                        underrun_evt = 1'b1;
`ifdef DAC_FEEDER_HOLD_LAST_EN
                        dac_rq_d   = 1'b1;
                        issue_st_d = IssReq;
`endif
                    end
                end
            end
            IssReq: begin
                underrun_evt = tick;
                if (dac_st) begin
                    dac_rq_d   = 1'b0;
                    issue_st_d = IssWaitDone;
                end
            end
            IssWaitDone: begin
                underrun_evt = tick;
                if (!dac_st) begin
                    issue_st_d = IssIdle;
                end
            end
            default: begin
                dac_rq_d   = 1'b0;
                issue_st_d = IssIdle;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push_ok, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        // A set event in the same cycle beats the clear.
        overflow_d = flags_clr ? 1'b0 : overflow_q;
        underrun_d = flags_clr ? 1'b0 : underrun_q;
        if (push && fifo_full) begin
            overflow_d = 1'b1;
        end
        if (underrun_evt) begin
            underrun_d = 1'b1;
        end
    end

    always_ff @(posedge clock_in) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            byte_st_q  <= ByteLow;
            issue_st_q <= IssIdle;
            low_byte_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            pacer_q    <= '0;
            dac_data_q <= '0;
            dac_rq_q   <= 1'b0;
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            byte_st_q  <= byte_st_d;
            issue_st_q <= issue_st_d;
            low_byte_q <= low_byte_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            pacer_q    <= pacer_d;
            dac_data_q <= dac_data_d;
            dac_rq_q   <= dac_rq_d;
            overflow_q <= overflow_d;
            underrun_q <= underrun_d;
        end
    end

    assign dac_data   = dac_data_q;
    assign dac_rq     = dac_rq_q;
    assign fifo_level = level_q;
    assign overflow   = overflow_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_dac_sample_feeder.sv
// Bench for dac_sample_feeder: scoreboard of expected samples, DAC handshake model,
// table-driven FIFO fill and hand-written timing corner cases.
module tb_dac_sample_feeder;
    localparam int unsigned Depth = 16;
    localparam int unsigned Cps   = 250;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        flags_clr;
    logic [15:0] dac_data;
    logic        dac_rq;
    logic        dac_st;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic        underrun;

    always #5 clk = ~clk;

    dac_sample_feeder #(
        .FIFO_DEPTH      (Depth),
        .CLKS_PER_SAMPLE (Cps)
    ) dut (
        .clock_in   (clk),
        .reset      (reset),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .flags_clr  (flags_clr),
        .dac_data   (dac_data),
        .dac_rq     (dac_rq),
        .dac_st     (dac_st),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .underrun   (underrun)
    );

    typedef struct {
        logic [15:0] word;
        logic [4:0]  exp_level;
        logic        exp_ovf;
    } vec_t;

    vec_t        vecs [17];
    int          n_vec = 0;
    int          n_fail = 0;
    int          req_count = 0;
    int          dac_hold = 100;
    int          m_pacer;
    logic        last_edge_tick;
    logic [15:0] sb [$];
    logic [15:0] last_sent = 16'h0;
    logic [15:0] held = 16'h0;
    logic [15:0] exp_word;
    logic        rq_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Reference sample pacer: tells which edge was a tick.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pacer        <= 0;
            last_edge_tick <= 1'b0;
        end else begin
            last_edge_tick <= (m_pacer == Cps - 1);
            m_pacer        <= (m_pacer == Cps - 1) ? 0 : m_pacer + 1;
        end
    end

    // DAC driver model: accept 2 cycles after a request, busy for dac_hold cycles.
    initial begin
        dac_st = 1'b0;
        forever begin
            @(negedge clk);
            if (dac_rq === 1'b1 && !dac_st) begin
                repeat (2) @(negedge clk);
                if (dac_rq === 1'b1) begin
                    dac_st = 1'b1;
                    repeat (dac_hold) @(negedge clk);
                    dac_st = 1'b0;
                end
            end
        end
    end

    // Request monitor: every new request is popped from the scoreboard and compared.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                held = 16'h0;
            end else if (dac_rq && !rq_prev) begin
                req_count++;
                check("rq_latency", {31'h0, last_edge_tick}, 32'h1);
                check("rq_while_st", {31'h0, dac_st}, 32'h0);
                if (sb.size() > 0) begin
                    exp_word = sb.pop_front();
                end else begin
`ifndef DAC_FEEDER_HOLD_LAST_EN
                    check("unexpected_rq", {31'h0, dac_rq}, 32'h0);
`endif
                    exp_word = last_sent;
                end
                check("dac_data", {16'h0, dac_data}, {16'h0, exp_word});
                last_sent = exp_word;
                held      = dac_data;
            end else begin
                check("data_stable", {16'h0, dac_data}, {16'h0, held});
            end
            rq_prev = dac_rq;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        byte_data  = b;
        byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        byte_data  = w[7:0];
        byte_valid = 1'b1;
        @(negedge clk);
        byte_data = w[15:8];
        if (sb.size() < Depth) sb.push_back(w);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        flags_clr = 1'b1;
        @(negedge clk);
        flags_clr = 1'b0;
    endtask

    task automatic wait_tick();
        for (int k = 0; k < Cps + 10; k++) begin
            @(negedge clk);
            if (last_edge_tick) return;
        end
        fail_now("tick_wait");
    endtask

    task automatic wait_pacer(input int v);
        for (int k = 0; k < Cps + 10; k++) begin
            @(negedge clk);
            if (m_pacer == v) return;
        end
        fail_now("pacer_wait");
    endtask

    task automatic wait_req(input int n, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (req_count >= n) return;
        end
        fail_now("req_wait");
    endtask

    initial begin
        int rbase;
        for (int i = 0; i < 17; i++) begin
            vecs[i].word      = 16'(i);
            vecs[i].exp_level = (i < 16) ? 5'(i + 1) : 5'd16;
            vecs[i].exp_ovf   = (i == 16);
        end

        reset      = 1'b1;
        byte_data  = 8'h0;
        byte_valid = 1'b0;
        flags_clr  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rq", {31'h0, dac_rq}, 32'h0);
        check("rst_data", {16'h0, dac_data}, 32'h0);
        check("rst_level", {27'h0, fifo_level}, 32'h0);
        check("rst_ovf", {31'h0, overflow}, 32'h0);
        check("rst_unf", {31'h0, underrun}, 32'h0);
        reset = 1'b0;

        // First sample, first tick.
        send_word(16'h1234);
        check("t1_level", {27'h0, fifo_level}, 32'h1);
        wait_tick();
        @(negedge clk);
        check("t1_pop_level", {27'h0, fifo_level}, 32'h0);
        wait_pacer(240);
        check("t1_one_request", req_count, 32'h1);
        wait_tick();
        @(negedge clk);
        check("t1_underrun", {31'h0, underrun}, 32'h1);
        pulse_clr();
        check("t1_clr_unf", {31'h0, underrun}, 32'h0);

        // Table-driven fill past full.
        rbase = req_count;
        for (int i = 0; i < 17; i++) begin
            send_word(vecs[i].word);
            check("fill_level", {27'h0, fifo_level}, {27'h0, vecs[i].exp_level});
            check("fill_overflow", {31'h0, overflow}, {31'h0, vecs[i].exp_ovf});
        end
        wait_req(rbase + 16, 16 * Cps + 100);

        // Three empty ticks.
        pulse_clr();
        check("t3_clr_ovf", {31'h0, overflow}, 32'h0);
        rbase = req_count;
        repeat (3) wait_tick();
        @(negedge clk);
        check("t3_underrun", {31'h0, underrun}, 32'h1);
`ifdef DAC_FEEDER_HOLD_LAST_EN
        check("t3_requests", req_count - rbase, 32'd3);
`else
        check("t3_requests", req_count - rbase, 32'd0);
`endif
        pulse_clr();
        check("t3_clr_unf", {31'h0, underrun}, 32'h0);

        // Driver busy across a tick.
        wait_tick();
        send_word(16'h5A5A);
        send_word(16'h6B6B);
        pulse_clr();
        dac_hold = 300;
        wait_tick();
        @(negedge clk);
        check("t4_pop_level", {27'h0, fifo_level}, 32'h1);
        check("t4_no_unf", {31'h0, underrun}, 32'h0);
        rbase = req_count;
        wait_tick();
        @(negedge clk);
        check("t4_busy_unf", {31'h0, underrun}, 32'h1);
        check("t4_busy_level", {27'h0, fifo_level}, 32'h1);
        check("t4_busy_noreq", req_count, rbase);
        dac_hold = 100;
        wait_tick();
        @(negedge clk);
        check("t4_late_pop", {27'h0, fifo_level}, 32'h0);

        // Push and pop on the same edge.
        wait_tick();
        for (int i = 0; i < 5; i++) send_word(16'h0100 + 16'(i));
        check("t5_level5", {27'h0, fifo_level}, 32'h5);
        wait_pacer(Cps - 2);
        send_word(16'h0105);
        check("t5_same_cycle", {27'h0, fifo_level}, 32'h5);

        // Reset during an active request with a half-received word.
        wait_tick();
        check("t6_level4", {27'h0, fifo_level}, 32'h4);
        check("t6_rq_up", {31'h0, dac_rq}, 32'h1);
        send_byte(8'hEE);
        reset = 1'b1;
        #1;
        check("t6_rq_async", {31'h0, dac_rq}, 32'h0);
        check("t6_level_async", {27'h0, fifo_level}, 32'h0);
        sb.delete();
        last_sent = 16'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("t6_ovf", {31'h0, overflow}, 32'h0);
        check("t6_unf", {31'h0, underrun}, 32'h0);
        check("t6_data", {16'h0, dac_data}, 32'h0);
        send_word(16'hABCD);
        check("t6_level1", {27'h0, fifo_level}, 32'h1);
        rbase = req_count;
        wait_req(rbase + 1, Cps + 20);
        @(negedge clk);
        check("t6_pop_level", {27'h0, fifo_level}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
